// File: rtl/decifra_cbc_controle.sv
`default_nettype none
// ============================================================================
// Module  : decifra_cbc_controle
// Brief   : CBC chaining wrapper around an external combinational 128-bit
//           block decipher, with valid/ready handshakes on both sides.
// Rev     : 1.0  initial release
// ============================================================================
module decifra_cbc_controle #(
    parameter int ESPERA   = 2,
    parameter int LARG_CNT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        iv,
    input  logic                carrega_iv,
    input  logic [127:0]        entrada,
    input  logic                entrada_valida,
    output logic                entrada_pronta,
    output logic [127:0]        bloco_dec,
    input  logic [127:0]        saida_dec,
    output logic [127:0]        saida,
    output logic                saida_valida,
    input  logic                saida_pronta,
    output logic                ocupado,
    output logic [LARG_CNT-1:0] contador_blocos
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        AGUARDA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    // Wait counter preload; the last AGUARDA cycle is the one where it reads 0.
    localparam logic [3:0] c_espera_ini = 4'(ESPERA - 1);

    estado_t               estado_q;
    logic [3:0]            espera_cnt_q;
    logic [127:0]          bloco_q;
    logic [127:0]          encad_q;
    logic [127:0]          saida_q;
    logic                  saida_valida_q;
    logic                  ocupado_q;
    logic [LARG_CNT-1:0]   contador_q;

    logic [127:0]          w_saida_d;

    assign w_saida_d = saida_dec ^ encad_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            espera_cnt_q   <= 4'd0;
            bloco_q        <= '0;
            encad_q        <= '0;
            saida_q        <= '0;
            saida_valida_q <= 1'b0;
            ocupado_q      <= 1'b0;
            contador_q     <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    // IV load wins over a simultaneous block offer.
                    if (carrega_iv) begin
                        encad_q <= iv;
                    end else if (entrada_valida) begin
                        bloco_q      <= entrada;
                        espera_cnt_q <= c_espera_ini;
                        estado_q     <= AGUARDA;
                        ocupado_q    <= 1'b1;
                    end
                end
                AGUARDA: begin
                    if (espera_cnt_q != 4'd0) begin
                        espera_cnt_q <= espera_cnt_q - 4'd1;
                    end else begin
                        saida_q        <= w_saida_d;
                        encad_q        <= bloco_q;
                        estado_q       <= ENTREGA;
                        saida_valida_q <= 1'b1;
                    end
                end
                ENTREGA: begin
                    if (saida_pronta) begin
                        contador_q     <= contador_q + 1'b1;
                        estado_q       <= OCIOSO;
                        saida_valida_q <= 1'b0;
                        ocupado_q      <= 1'b0;
                    end
                end
                default: begin
                    estado_q       <= OCIOSO;
                    saida_valida_q <= 1'b0;
                    ocupado_q      <= 1'b0;
                end
            endcase
        end
    end

    assign entrada_pronta  = (estado_q == OCIOSO) && !carrega_iv;
    assign bloco_dec       = bloco_q;
    assign saida           = saida_q;
    assign saida_valida    = saida_valida_q;
    assign ocupado         = ocupado_q;
    assign contador_blocos = contador_q;

endmodule
`default_nettype wire

// File: tb/tb_decifra_cbc_controle.sv
`default_nettype none
// ============================================================================
// Module  : tb_decifra_cbc_controle
// Brief   : Directed self-checking bench for decifra_cbc_controle with an
//           XOR-with-constant stand-in for the block decipher.
// Rev     : 1.0  initial release
// ============================================================================
module tb_decifra_cbc_controle;

    localparam logic [127:0] K = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] iv;
    logic         carrega_iv;
    logic [127:0] entrada;
    logic         entrada_valida;
    logic         entrada_pronta;
    logic [127:0] bloco_dec;
    logic [127:0] saida_dec;
    logic [127:0] saida;
    logic         saida_valida;
    logic         saida_pronta;
    logic         ocupado;
    logic [15:0]  contador_blocos;

    int n_checks = 0;
    int n_fail   = 0;

    assign saida_dec = bloco_dec ^ K;

    always #5 clock = ~clock;

    decifra_cbc_controle #(.ESPERA(2), .LARG_CNT(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .iv              (iv),
        .carrega_iv      (carrega_iv),
        .entrada         (entrada),
        .entrada_valida  (entrada_valida),
        .entrada_pronta  (entrada_pronta),
        .bloco_dec       (bloco_dec),
        .saida_dec       (saida_dec),
        .saida           (saida),
        .saida_valida    (saida_valida),
        .saida_pronta    (saida_pronta),
        .ocupado         (ocupado),
        .contador_blocos (contador_blocos)
    );

    // Called at the negedge right after the accept edge; returns edges since accept, -1 on timeout.
    task automatic wait_valida(output int lat);
        lat = 1;
        while (saida_valida !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (saida_valida !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1; carrega_iv = 1'b0; entrada_valida = 1'b0; saida_pronta = 1'b0;
        iv = '0; entrada = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (saida_valida !== 1'b0) begin n_fail++; $display("FAIL reset_valida got %b want 0", saida_valida); end
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
        n_checks++; if (contador_blocos !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", contador_blocos); end
        n_checks++; if (saida !== 128'h0) begin n_fail++; $display("FAIL reset_saida got %h want 0", saida); end
        n_checks++; if (bloco_dec !== 128'h0) begin n_fail++; $display("FAIL reset_bloco got %h want 0", bloco_dec); end
        n_checks++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL reset_pronta got %b want 1", entrada_pronta); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int lat;
        carrega_iv = 1'b1; iv = 128'h1;
        #1;
        n_checks++; if (entrada_pronta !== 1'b0) begin n_fail++; $display("FAIL iv_pronta got %b want 0", entrada_pronta); end
        @(negedge clock);
        carrega_iv = 1'b0;
        entrada = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA; entrada_valida = 1'b1;
        #1;
        n_checks++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL single_pronta got %b want 1", entrada_pronta); end
        @(negedge clock);
        entrada_valida = 1'b0;
        n_checks++; if (ocupado !== 1'b1) begin n_fail++; $display("FAIL single_ocupado got %b want 1", ocupado); end
        wait_valida(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", lat); end
        n_checks++; if (saida !== 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A4) begin n_fail++; $display("FAIL single_saida got %h want a5..a4", saida); end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (saida_valida !== 1'b0) begin n_fail++; $display("FAIL single_valida_drop got %b want 0", saida_valida); end
        n_checks++; if (contador_blocos !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", contador_blocos); end
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", ocupado); end
    endtask

    task automatic test_chaining;
        int lat;
        entrada = 128'h5555_5555_5555_5555_5555_5555_5555_5555; entrada_valida = 1'b1;
        @(negedge clock);
        entrada_valida = 1'b0;
        wait_valida(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL chain_latency got %0d want 3", lat); end
        n_checks++; if (saida !== 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0) begin n_fail++; $display("FAIL chain_saida got %h want f0..f0", saida); end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (contador_blocos !== 16'd2) begin n_fail++; $display("FAIL chain_cnt got %0d want 2", contador_blocos); end
    endtask

    task automatic test_backpressure;
        int lat;
        entrada = 128'h0; entrada_valida = 1'b1;
        @(negedge clock);
        entrada = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        wait_valida(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (saida !== 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A) begin n_fail++; $display("FAIL bp_saida[%0d] got %h want 5a..5a", i, saida); end
            n_checks++; if (entrada_pronta !== 1'b0) begin n_fail++; $display("FAIL bp_pronta[%0d] got %b want 0", i, entrada_pronta); end
            n_checks++; if (bloco_dec !== 128'h0) begin n_fail++; $display("FAIL bp_bloco[%0d] got %h want 0", i, bloco_dec); end
            n_checks++; if (saida_valida !== 1'b1) begin n_fail++; $display("FAIL bp_valida[%0d] got %b want 1", i, saida_valida); end
            @(negedge clock);
        end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL bp_pronta_after got %b want 1", entrada_pronta); end
        n_checks++; if (bloco_dec !== 128'h0) begin n_fail++; $display("FAIL bp_no_early_accept got %h want 0", bloco_dec); end
        @(negedge clock);
        entrada_valida = 1'b0;
        n_checks++; if (bloco_dec !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL bp_accept got %h want ff..ff", bloco_dec); end
        wait_valida(lat);
        n_checks++; if (saida !== 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0) begin n_fail++; $display("FAIL bp_second_saida got %h want f0..f0", saida); end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (contador_blocos !== 16'd4) begin n_fail++; $display("FAIL bp_cnt got %0d want 4", contador_blocos); end
    endtask

    task automatic test_simultaneous;
        int lat;
        iv = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        carrega_iv = 1'b1; entrada = 128'h0; entrada_valida = 1'b1;
        #1;
        n_checks++; if (entrada_pronta !== 1'b0) begin n_fail++; $display("FAIL sim_pronta got %b want 0", entrada_pronta); end
        @(negedge clock);
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL sim_not_accepted got %b want 0", ocupado); end
        carrega_iv = 1'b0;
        #1;
        n_checks++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL sim_pronta_next got %b want 1", entrada_pronta); end
        @(negedge clock);
        entrada_valida = 1'b0;
        n_checks++; if (ocupado !== 1'b1 || bloco_dec !== 128'h0) begin n_fail++; $display("FAIL sim_accept got ocupado=%b bloco=%h want 1/0", ocupado, bloco_dec); end
        wait_valida(lat);
        n_checks++; if (saida !== 128'h0E2C_4A68_86A4_C2E0_F1D3_B597_795B_3D1F) begin n_fail++; $display("FAIL sim_saida got %h want 0e2c..3d1f", saida); end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (contador_blocos !== 16'd5) begin n_fail++; $display("FAIL sim_cnt got %0d want 5", contador_blocos); end
    endtask

    task automatic test_reset_aguarda;
        int lat;
        bit seen;
        entrada = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA; entrada_valida = 1'b1;
        @(negedge clock);
        entrada_valida = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL rst_ocupado got %b want 0", ocupado); end
        n_checks++; if (bloco_dec !== 128'h0) begin n_fail++; $display("FAIL rst_bloco got %h want 0", bloco_dec); end
        n_checks++; if (contador_blocos !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", contador_blocos); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (saida_valida !== 1'b0) seen = 1'b1;
            @(negedge clock);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_valida got %b want 0", seen); end
        entrada = 128'h3; entrada_valida = 1'b1;
        @(negedge clock);
        entrada_valida = 1'b0;
        wait_valida(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rst_latency got %0d want 3", lat); end
        n_checks++; if (saida !== 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0C) begin n_fail++; $display("FAIL rst_saida got %h want 0f..0c", saida); end
        saida_pronta = 1'b1;
        @(negedge clock);
        saida_pronta = 1'b0;
        n_checks++; if (contador_blocos !== 16'd1) begin n_fail++; $display("FAIL rst_cnt_after got %0d want 1", contador_blocos); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chaining();
        test_backpressure();
        test_simultaneous();
        test_reset_aguarda();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
